fc_2_readout: RTL and testbench

FC_2_READOUT -- requirements
Module: fc_2_readout

---
 rtl/fc_2_readout_pkg.sv | 18 +
 rtl/fc_2_readout_argmax.sv | 16 +
 rtl/fc_2_readout.sv | 179 +++++++++++++++++
 tb/tb_fc_2_readout.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_2_readout_pkg.sv
// Shared constants and state encodings for the fc_2 result readout.
// Holds data/class sizes, result-BRAM base address and one-hot FSM states.
package fc_2_readout_pkg;

   localparam int DATA_SIZE        = 8;
   localparam int FC2_SIZE         = 10;
   localparam int ADDR_W           = 15;
   localparam int IDX_W            = 4;
   localparam int RESULT_BASE_ADDR = 18400;

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_READ   = 4'b0010,
      S_STREAM = 4'b0100,
      S_DONE   = 4'b1000
   } state_t;

endpackage

// File: rtl/fc_2_readout_argmax.sv
// Signed argmax step: asserts o_take when the candidate replaces the max.
// Ports: i_first (first score seeds max), i_cand, i_max, o_take.
module fc_2_argmax
   import fc_2_readout_pkg::*;
(
   input  logic                 i_first,
   input  logic [DATA_SIZE-1:0] i_cand,
   input  logic [DATA_SIZE-1:0] i_max,
   output logic                 o_take
);

   // strictly greater keeps the lowest index on ties
   assign o_take = i_first |
                   ($signed(i_cand) > $signed(i_max));

endmodule

// File: rtl/fc_2_readout.sv
// Reads NUM_CLASSES signed scores from result BRAM and reports the argmax.
// Ports: clk, rst (async active-low), readout_en, start, BRAM port,
// scores/class_* results, readout_done, tx_* byte stream.
// Macro FC2_READOUT_STREAM_EN adds the 11-byte output stream.
module fc_2_readout
   import fc_2_readout_pkg::*;
#(
   parameter int RESULT_BASE = RESULT_BASE_ADDR,
   parameter int NUM_CLASSES = FC2_SIZE,
   parameter int RD_LAT      = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       readout_en,
   input  logic                       start,
   input  logic [7:0]                 result_bram_douta,
   output logic                       result_bram_ena,
   output logic [14:0]                result_bram_addra,
   output logic [8*NUM_CLASSES-1:0]   scores,
   output logic [3:0]                 class_idx,
   output logic [7:0]                 class_score,
   output logic                       class_vld,
   output logic                       readout_done,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   output logic                       tx_last,
   input  logic                       tx_ready
);

   localparam int SW = $clog2(RD_LAT + 2);
   localparam logic [SW-1:0] SUB_PRE = SW'(RD_LAT - 1);
   localparam logic [SW-1:0] SUB_CAP = SW'(RD_LAT);
   localparam logic [SW-1:0] SUB_FIN = SW'(RD_LAT + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

   state_t                   r_state;
   state_t                   w_next;
   logic [SW-1:0]            r_sub;
   logic [IDX_W-1:0]         r_idx;
   logic [7:0]               r_max;
   logic [IDX_W-1:0]         r_max_idx;
   logic                     r_ena;
   logic [ADDR_W-1:0]        r_addr;
   logic [8*NUM_CLASSES-1:0] r_scores;
   logic [3:0]               r_cls_idx;
   logic [7:0]               r_cls_score;
   logic                     r_cls_vld;
   logic                     w_take;
   logic                     w_cap;
   logic                     w_fin;

   // sub-cycle RD_LAT captures; SUB_FIN is one extra cycle
   // after the last capture that publishes the result
   assign w_cap = (r_state == S_READ) && (r_sub == SUB_CAP);
   assign w_fin = (r_state == S_READ) && (r_sub == SUB_FIN);

   fc_2_argmax u_argmax (
      .i_first (r_idx == '0),
      .i_cand  (result_bram_douta),
      .i_max   (r_max),
      .o_take  (w_take)
   );

`ifdef FC2_READOUT_STREAM_EN
   localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NUM_CLASSES);
   logic [IDX_W-1:0] r_byte;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else if (readout_en) r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_next = S_READ;
`ifdef FC2_READOUT_STREAM_EN
         S_READ: if (w_fin) w_next = S_STREAM;
         S_STREAM:
            if (tx_ready && r_byte == BYTE_LAST)
               w_next = S_DONE;
`else
         S_READ: if (w_fin) w_next = S_DONE;
`endif
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      readout_done = (r_state == S_DONE);
`ifdef FC2_READOUT_STREAM_EN
      tx_valid = (r_state == S_STREAM);
      tx_last  = tx_valid && (r_byte == BYTE_LAST);
      tx_data  = {4'b0, r_cls_idx};
      for (int k = 0; k < NUM_CLASSES; k++)
         if (r_byte == IDX_W'(k))
            tx_data = r_scores[8*(NUM_CLASSES-k)-1 -: 8];
`else
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
`endif
   end

`ifdef FC2_READOUT_STREAM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_byte <= '0;
      else if (readout_en) begin
         if (w_fin) r_byte <= '0;
         else if (r_state == S_STREAM && tx_ready)
            r_byte <= r_byte + 1'b1;
      end
   end
`else
   logic w_unused_tx_ready;
   assign w_unused_tx_ready = tx_ready;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sub       <= '0;
         r_idx       <= '0;
         r_max       <= '0;
         r_max_idx   <= '0;
         r_ena       <= 1'b0;
         r_addr      <= '0;
         r_scores    <= '0;
         r_cls_idx   <= '0;
         r_cls_score <= '0;
         r_cls_vld   <= 1'b0;
      end else if (readout_en) begin
         if (r_state == S_IDLE) begin
            if (start) begin
               r_cls_vld <= 1'b0;
               r_idx     <= '0;
               r_sub     <= '0;
               r_ena     <= 1'b1;
               r_addr    <= ADDR_W'(RESULT_BASE);
            end
         end else if (r_state == S_READ) begin
            if (w_fin) begin
               r_cls_idx   <= r_max_idx;
               r_cls_score <= r_max;
               r_cls_vld   <= 1'b1;
            end else if (w_cap) begin
               for (int k = 0; k < NUM_CLASSES; k++)
                  if (r_idx == IDX_W'(k))
                     r_scores[8*(NUM_CLASSES-k)-1 -: 8]
                        <= result_bram_douta;
               if (w_take) begin
                  r_max     <= result_bram_douta;
                  r_max_idx <= r_idx;
               end
               if (r_idx == IDX_LAST) r_sub <= SUB_FIN;
               else begin
                  r_idx  <= r_idx + 1'b1;
                  r_sub  <= '0;
                  r_ena  <= 1'b1;
                  r_addr <= ADDR_W'(RESULT_BASE)
                          + ADDR_W'(r_idx) + ADDR_W'(1);
               end
            end else begin
               r_sub <= r_sub + 1'b1;
               if (r_sub == SUB_PRE) r_ena <= 1'b0;
            end
         end
      end
   end

   assign result_bram_ena   = r_ena;
   assign result_bram_addra = r_addr;
   assign scores            = r_scores;
   assign class_idx         = r_cls_idx;
   assign class_score       = r_cls_score;
   assign class_vld         = r_cls_vld;

endmodule

// File: tb/tb_fc_2_readout.sv
// Directed bench for fc_2_readout with a 3-cycle-latency BRAM model.
// Vector table for argmax cases plus reset-abort, duplicate-start, stream.
module tb_fc_2_readout;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        readout_en = 1'b1;
   logic        start = 1'b0;
   logic        tx_ready = 1'b1;
   logic [7:0]  douta;
   logic        ena;
   logic [14:0] addra;
   logic [79:0] scores;
   logic [3:0]  class_idx;
   logic [7:0]  class_score;
   logic        class_vld;
   logic        readout_done;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_last;

   always #5 clk = ~clk;

   fc_2_readout dut (
      .clk               (clk),
      .rst               (rst),
      .readout_en        (readout_en),
      .start             (start),
      .result_bram_douta (douta),
      .result_bram_ena   (ena),
      .result_bram_addra (addra),
      .scores            (scores),
      .class_idx         (class_idx),
      .class_score       (class_score),
      .class_vld         (class_vld),
      .readout_done      (readout_done),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_last           (tx_last),
      .tx_ready          (tx_ready)
   );

   logic [7:0] mem [10];
   logic [7:0] p0, p1;

   function automatic logic [7:0] bram_rd(input logic [14:0] a);
      int o;
      o = int'(a) - 18400;
      if (o >= 0 && o < 10) return mem[o];
      return 8'h00;
   endfunction

   always @(posedge clk) begin
      if (ena) p0 <= bram_rd(addra);
      p1    <= p0;
      douta <= p1;
   end

   int          done_cnt = 0;
   logic        prev_ena = 1'b0;
   logic [14:0] prev_addr = '0;
   logic [14:0] addr_log [$];

   always @(posedge clk) begin
      if (readout_done) done_cnt <= done_cnt + 1;
      if (ena && (!prev_ena || addra != prev_addr))
         addr_log.push_back(addra);
      prev_ena  <= ena;
      prev_addr <= addra;
   end

`ifdef FC2_READOUT_STREAM_EN
   logic [7:0] tx_log [$];
   logic       last_log [$];
   logic       stalled = 1'b0;
   logic [7:0] stall_data = '0;
   int         stall_err = 0;

   always @(posedge clk) begin
      if (tx_valid) begin
         if (stalled && tx_data != stall_data)
            stall_err <= stall_err + 1;
         if (tx_ready) begin
            tx_log.push_back(tx_data);
            last_log.push_back(tx_last);
            stalled <= 1'b0;
         end else begin
            stalled    <= 1'b1;
            stall_data <= tx_data;
         end
      end
   end
`endif

   typedef struct {
      logic [79:0] s;
      logic [3:0]  idx;
      logic [7:0]  sc;
   } vec_t;

   vec_t vecs [6];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm,
                      input logic [79:0] act,
                      input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load(input logic [79:0] s);
      for (int k = 0; k < 10; k++) mem[k] = s[8*(10-k)-1 -: 8];
   endtask

   // returns #1 after the edge that samples start
   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_vec(input string nm, input vec_t v,
                          input bit dup);
      int b0, a0, cyc;
      b0 = done_cnt;
      a0 = addr_log.size();
      load(v.s);
      pulse_start();
      chk({nm, "_vld_clr"}, 80'(class_vld), 80'd0);
      cyc = 0;
      while (cyc < 100 && !class_vld) begin
         @(posedge clk);
         #1;
         cyc++;
         start = dup && (cyc == 4 || cyc == 19);
      end
      start = 1'b0;
      chk({nm, "_latency"}, 80'(cyc), 80'd41);
      chk({nm, "_idx"}, 80'(class_idx), 80'(v.idx));
      chk({nm, "_score"}, 80'(class_score), 80'(v.sc));
      chk({nm, "_scores"}, scores, v.s);
      repeat (30) @(posedge clk);
      #1;
      chk({nm, "_done_cnt"}, 80'(done_cnt - b0), 80'd1);
      chk({nm, "_addr_n"}, 80'(addr_log.size() - a0), 80'd10);
      for (int k = 0; k < 10; k++)
         if (a0 + k < addr_log.size())
            chk($sformatf("%s_addr%0d", nm, k),
                80'(addr_log[a0+k]), 80'(18400 + k));
   endtask

   initial begin
      int b0, a0;
      vecs[0] = '{80'h05FD140714000102807F, 4'd9, 8'h7F};
      vecs[1] = '{{10{8'h14}}, 4'd0, 8'h14};
      vecs[2] = '{{10{8'hFF}}, 4'd0, 8'hFF};
      vecs[3] = '{{8'h80, {9{8'h00}}}, 4'd1, 8'h00};
      vecs[4] = '{80'h0102030405060708090A, 4'd9, 8'h0A};
      vecs[5] = '{80'h5000005A0000005A0000, 4'd3, 8'h5A};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ena", 80'(ena), 80'd0);
      chk("rst_addr", 80'(addra), 80'd0);
      chk("rst_scores", scores, 80'd0);
      chk("rst_idx", 80'(class_idx), 80'd0);
      chk("rst_score", 80'(class_score), 80'd0);
      chk("rst_vld", 80'(class_vld), 80'd0);
      chk("rst_done", 80'(readout_done), 80'd0);
      chk("rst_tx", 80'({tx_valid, tx_last, tx_data}), 80'd0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 6; i++)
         run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

      // start while disabled must be ignored
      b0 = done_cnt;
      readout_en = 1'b0;
      pulse_start();
      repeat (50) @(posedge clk);
      #1;
      chk("en_low_done", 80'(done_cnt - b0), 80'd0);
      chk("en_low_vld", 80'(class_vld), 80'd1);
      @(negedge clk) readout_en = 1'b1;

      // reset mid-readout
      b0 = done_cnt;
      load(vecs[0].s);
      pulse_start();
      repeat (14) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      a0 = addr_log.size();
      chk("abort_ena", 80'(ena), 80'd0);
      chk("abort_addr", 80'(addra), 80'd0);
      chk("abort_scores", scores, 80'd0);
      chk("abort_cls",
          80'({class_idx, class_score, class_vld}), 80'd0);
      chk("abort_done", 80'(readout_done), 80'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("abort_no_done", 80'(done_cnt - b0), 80'd0);
      chk("abort_no_addr", 80'(addr_log.size() - a0), 80'd0);
      run_vec("after_rst", vecs[0], 1'b0);

      run_vec("dup_start", vecs[5], 1'b1);

`ifdef FC2_READOUT_STREAM_EN
      begin
         int t0, cyc, at_done;
         b0 = done_cnt;
         t0 = tx_log.size();
         at_done = -1;
         load(vecs[0].s);
         tx_ready = 1'b0;
         pulse_start();
         cyc = 0;
         while (cyc < 300 && done_cnt == b0) begin
            @(negedge clk) tx_ready = ~tx_ready;
            cyc++;
         end
         if (done_cnt != b0) at_done = tx_log.size() - t0;
         tx_ready = 1'b1;
         chk("st_done_seen", 80'(done_cnt != b0), 80'd1);
         chk("st_bytes_before_done", 80'(at_done), 80'd11);
         chk("st_stall_stable", 80'(stall_err), 80'd0);
         for (int k = 0; k < 11; k++)
            if (t0 + k < tx_log.size()) begin
               chk($sformatf("st_byte%0d", k),
                   80'(tx_log[t0+k]),
                   k < 10 ? 80'(vecs[0].s[8*(10-k)-1 -: 8])
                          : 80'h09);
               chk($sformatf("st_last%0d", k),
                   80'(last_log[t0+k]), 80'(k == 10));
            end
      end
`else
      chk("tx_tied", 80'({tx_valid, tx_last, tx_data}), 80'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
